// File: rtl/rx_packet_assembler.sv
// ---------------------------------------------------------------------------
// rx_packet_assembler
//
// Receive-side packet assembler for the full-speed USB device core. Consumes
// the de-stuffed bit stream from the J/K line decoder, packs bits LSB-first
// into bytes, validates the PID (low nibble must equal the complement of the
// high nibble), and checks CRC5 (token) or CRC16 (data) residuals. Emits the
// bytes after the PID, CRC bytes included, plus per-packet status.
//
// Optional feature macro: RX_CRC_CHECK_EN
//   defined   : CRC5/CRC16 registers present, err_crc reports residual errors
//   undefined : no CRC logic, err_crc is tied 0 and pkt_ok ignores CRC
//
// Ports
//   clk48       in   48 MHz core clock
//   reset       in   synchronous, active-high reset
//   bit_in      in   decoded data bit, qualified by bit_valid
//   bit_valid   in   one-cycle strobe per de-stuffed bit
//   bus_sop     in   start-of-packet strobe
//   bus_eop     in   end-of-packet strobe
//   bus_reset   in   USB bus reset level; forces IDLE, clears outputs but pid
//   pid         out  last accepted PID[3:0]
//   pid_valid   out  pulse when a PID passes the complement check
//   byte_out    out  assembled byte after the PID
//   byte_valid  out  pulse per byte_out
//   byte_count  out  bytes emitted in current/last packet, excluding the PID
//   pkt_end     out  pulse at end of packet; status valid in that cycle
//   pkt_ok      out  no error flag set
//   err_pid     out  PID check failed (or EOP before the PID completed)
//   err_crc     out  CRC residual mismatch
//   err_align   out  bit count not a multiple of 8 at EOP
//   err_len     out  more than MAX_BYTES bytes after the PID
// ---------------------------------------------------------------------------
module rx_packet_assembler #(
  parameter int unsigned MAX_BYTES = 1026
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  input  logic        bus_sop,
  input  logic        bus_eop,
  input  logic        bus_reset,
  output logic [3:0]  pid,
  output logic        pid_valid,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic [10:0] byte_count,
  output logic        pkt_end,
  output logic        pkt_ok,
  output logic        err_pid,
  output logic        err_crc,
  output logic        err_align,
  output logic        err_len
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PID   = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [10:0] MAX_CNT = 11'(MAX_BYTES);

  // Registered state and outputs
  state_t      state_q,      state_d;
  logic [7:0]  sr_q,         sr_d;
  logic [2:0]  bitcnt_q,     bitcnt_d;
  logic [10:0] cnt_q,        cnt_d;
  logic        pid_bad_q,    pid_bad_d;
  logic        len_bad_q,    len_bad_d;
  logic [3:0]  pid_q,        pid_d;
  logic        pid_valid_q,  pid_valid_d;
  logic [7:0]  byte_out_q,   byte_out_d;
  logic        byte_valid_q, byte_valid_d;
  logic [10:0] byte_count_q, byte_count_d;
  logic        pkt_end_q,    pkt_end_d;
  logic        pkt_ok_q,     pkt_ok_d;
  logic        err_pid_q,    err_pid_d;
  logic        err_align_q,  err_align_d;
  logic        err_len_q,    err_len_d;

  // Values after this cycle's bit is absorbed, before SOP/EOP handling
  state_t      state_m;
  logic [7:0]  sr_m;
  logic [2:0]  bitcnt_m;
  logic [10:0] cnt_m;
  logic        pid_bad_m;
  logic        len_bad_m;

  logic        shifting;
  logic        byte_done;
  logic        eop_fire;
  logic [7:0]  sr_shift;
  logic        fail_pid;
  logic        fail_align;
  logic        fail_crc;

`ifdef RX_CRC_CHECK_EN
  logic [4:0]  crc5_q,  crc5_d,  crc5_m;
  logic [15:0] crc16_q, crc16_d, crc16_m;
  logic        err_crc_q, err_crc_d;

  // Serial CRC5 update, poly x^5+x^2+1, bits in wire order
  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[4];
    crc5_step = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // Serial CRC16 update, poly x^16+x^15+x^2+1, bits in wire order
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    crc16_step = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction
`endif

  assign shifting  = bit_valid && ((state_q == ST_PID) || (state_q == ST_DATA));
  assign sr_shift  = {bit_in, sr_q[7:1]};
  assign byte_done = shifting && (bitcnt_q == 3'd7);
  assign eop_fire  = bus_eop && (state_q != ST_IDLE);

  // Next-state logic: absorb the bit first, then apply EOP, then SOP
  always_comb begin
    state_m   = state_q;
    cnt_m     = cnt_q;
    pid_bad_m = pid_bad_q;
    len_bad_m = len_bad_q;

    pid_d        = pid_q;
    pid_valid_d  = 1'b0;
    byte_out_d   = byte_out_q;
    byte_valid_d = 1'b0;
    byte_count_d = byte_count_q;
    pkt_end_d    = 1'b0;
    pkt_ok_d     = pkt_ok_q;
    err_pid_d    = err_pid_q;
    err_align_d  = err_align_q;
    err_len_d    = err_len_q;
    fail_pid     = 1'b0;
    fail_align   = 1'b0;
    fail_crc     = 1'b0;

    if (shifting) begin
      sr_m     = sr_shift;
      bitcnt_m = bitcnt_q + 3'd1;
    end else begin
      sr_m     = sr_q;
      bitcnt_m = bitcnt_q;
    end

`ifdef RX_CRC_CHECK_EN
    err_crc_d = err_crc_q;
    if (shifting && (state_q == ST_DATA)) begin
      crc5_m  = crc5_step(crc5_q, bit_in);
      crc16_m = crc16_step(crc16_q, bit_in);
    end else begin
      crc5_m  = crc5_q;
      crc16_m = crc16_q;
    end
`endif

    case (state_q)
      ST_PID: begin
        if (byte_done) begin
          if (sr_shift[3:0] == ~sr_shift[7:4]) begin
            pid_d       = sr_shift[3:0];
            pid_valid_d = 1'b1;
            state_m     = ST_DATA;
          end else begin
            pid_bad_m = 1'b1;
            state_m   = ST_DRAIN;
          end
        end else begin
          state_m = ST_PID;
        end
      end
      ST_DATA: begin
        if (byte_done) begin
          // A byte beyond MAX_BYTES is swallowed; the count stays saturated
          if (cnt_q == MAX_CNT) begin
            len_bad_m = 1'b1;
            state_m   = ST_DRAIN;
          end else begin
            byte_out_d   = sr_shift;
            byte_valid_d = 1'b1;
            cnt_m        = cnt_q + 11'd1;
          end
        end else begin
          state_m = ST_DATA;
        end
      end
      default: begin
        state_m = state_q;
      end
    endcase

    // Status for the packet that ends now, computed on post-bit values
    if (eop_fire) begin
      fail_pid   = (state_m == ST_PID) || pid_bad_m;
      fail_align = (state_m == ST_PID) || (bitcnt_m != 3'd0);
`ifdef RX_CRC_CHECK_EN
      // CRC only means something once this packet's PID was accepted
      if (!fail_pid && (pid_d[1:0] == 2'b01)) begin
        fail_crc = (crc5_m != 5'b01100);
      end else if (!fail_pid && (pid_d[1:0] == 2'b11)) begin
        fail_crc = (crc16_m != 16'h800D);
      end else begin
        fail_crc = 1'b0;
      end
      err_crc_d = fail_crc;
`endif
      pkt_end_d    = 1'b1;
      err_pid_d    = fail_pid;
      err_align_d  = fail_align;
      err_len_d    = len_bad_m;
      pkt_ok_d     = ~(fail_pid | fail_align | fail_crc | len_bad_m);
      byte_count_d = cnt_m;
    end else if (bus_sop) begin
      // Fresh packet (or abort of the current one): status starts clean
      pid_d        = pid_q;
      pid_valid_d  = 1'b0;
      byte_valid_d = 1'b0;
      byte_count_d = 11'd0;
      pkt_ok_d     = 1'b0;
      err_pid_d    = 1'b0;
      err_align_d  = 1'b0;
      err_len_d    = 1'b0;
`ifdef RX_CRC_CHECK_EN
      err_crc_d    = 1'b0;
`endif
    end else begin
      byte_count_d = cnt_m;
    end

    // SOP restarts the datapath even when it coincides with EOP
    if (bus_sop) begin
      state_d   = ST_PID;
      sr_d      = 8'h00;
      bitcnt_d  = 3'd0;
      cnt_d     = 11'd0;
      pid_bad_d = 1'b0;
      len_bad_d = 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc5_d    = 5'h1F;
      crc16_d   = 16'hFFFF;
`endif
    end else begin
      state_d   = eop_fire ? ST_IDLE : state_m;
      sr_d      = sr_m;
      bitcnt_d  = bitcnt_m;
      cnt_d     = cnt_m;
      pid_bad_d = pid_bad_m;
      len_bad_d = len_bad_m;
`ifdef RX_CRC_CHECK_EN
      crc5_d    = crc5_m;
      crc16_d   = crc16_m;
`endif
    end
  end

  // State and output registers; bus_reset keeps only the last PID
  always_ff @(posedge clk48) begin
    if (reset || bus_reset) begin
      state_q      <= ST_IDLE;
      sr_q         <= 8'h00;
      bitcnt_q     <= 3'd0;
      cnt_q        <= 11'd0;
      pid_bad_q    <= 1'b0;
      len_bad_q    <= 1'b0;
      pid_q        <= reset ? 4'h0 : pid_q;
      pid_valid_q  <= 1'b0;
      byte_out_q   <= 8'h00;
      byte_valid_q <= 1'b0;
      byte_count_q <= 11'd0;
      pkt_end_q    <= 1'b0;
      pkt_ok_q     <= 1'b0;
      err_pid_q    <= 1'b0;
      err_align_q  <= 1'b0;
      err_len_q    <= 1'b0;
`ifdef RX_CRC_CHECK_EN
      crc5_q       <= 5'h1F;
      crc16_q      <= 16'hFFFF;
      err_crc_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bitcnt_q     <= bitcnt_d;
      cnt_q        <= cnt_d;
      pid_bad_q    <= pid_bad_d;
      len_bad_q    <= len_bad_d;
      pid_q        <= pid_d;
      pid_valid_q  <= pid_valid_d;
      byte_out_q   <= byte_out_d;
      byte_valid_q <= byte_valid_d;
      byte_count_q <= byte_count_d;
      pkt_end_q    <= pkt_end_d;
      pkt_ok_q     <= pkt_ok_d;
      err_pid_q    <= err_pid_d;
      err_align_q  <= err_align_d;
      err_len_q    <= err_len_d;
`ifdef RX_CRC_CHECK_EN
      crc5_q       <= crc5_d;
      crc16_q      <= crc16_d;
      err_crc_q    <= err_crc_d;
`endif
    end
  end

  assign pid        = pid_q;
  assign pid_valid  = pid_valid_q;
  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign byte_count = byte_count_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_ok     = pkt_ok_q;
  assign err_pid    = err_pid_q;
  assign err_align  = err_align_q;
  assign err_len    = err_len_q;
`ifdef RX_CRC_CHECK_EN
  assign err_crc    = err_crc_q;
`else
  assign err_crc    = 1'b0;
`endif

endmodule

// File: doc/rx_packet_assembler.md
# rx_packet_assembler

Receive-side packet assembler for the full-speed USB device core. It sits directly downstream of the J/K line decoder and consumes its de-stuffed NRZI bit stream and its SOP/EOP/bus-reset strobes. It packs bits LSB-first into bytes, validates the PID, and checks CRC5 (token) or CRC16 (data). It emits a byte stream plus per-packet status to the protocol engine.

## Interface
- MAX_BYTES, 1026: maximum bytes after the PID, CRC included; exceeding it sets err_len.
- clk48  in  1  48 MHz core clock
- reset  in  1  synchronous, active-high
- bit_in  in  1  decoded data bit, qualified by bit_valid
- bit_valid  in  1  one-cycle strobe per de-stuffed bit
- bus_sop  in  1  start-of-packet strobe
- bus_eop  in  1  end-of-packet strobe
- bus_reset  in  1  USB bus reset (SE0 timeout), level
- pid  out  4  accepted PID[3:0], held until next accepted PID
- pid_valid  out  1  one-cycle pulse when the PID passes the complement check
- byte_out  out  8  assembled byte after the PID; CRC bytes included
- byte_valid  out  1  one-cycle pulse per byte_out
- byte_count  out  11  bytes emitted in current/last packet, excluding the PID
- pkt_end  out  1  one-cycle pulse at end of packet; status outputs are valid in that cycle
- pkt_ok  out  1  no error flag set; meaningful with pkt_end
- err_pid  out  1  PID check failed
- err_crc  out  1  CRC residual mismatch
- err_align  out  1  bit count after SOP not a multiple of 8 at EOP
- err_len  out  1  more than MAX_BYTES bytes after the PID

## Operation
- All outputs reset to 0. The FSM resets to IDLE. The shift register, bit counter and CRC registers clear.
- States: IDLE, PID, DATA, DRAIN.
- IDLE: on bus_sop, go to PID. Clear the bit counter (3 b), byte_count, error flags, CRC5 to 5'h1F and CRC16 to 16'hFFFF.
- Shifting: on each bit_valid, shift right with bit_in entering bit 7. Every 8th bit completes a byte.
- PID: on byte completion, check sr[3:0] == ~sr[7:4].
  - Pass: latch pid, pulse pid_valid, go to DATA.
  - Fail: set err_pid, go to DRAIN.
- DATA: each completed byte drives byte_out and pulses byte_valid, then byte_count increments.
  - Every bit also feeds both CRC registers (CRC5 poly x^5+x^2+1, CRC16 poly x^16+x^15+x^2+1, wire order).
  - If byte_count would exceed MAX_BYTES, set err_len, go to DRAIN, and stop emitting bytes. byte_count saturates.
- DRAIN: ignore bits; wait for EOP.
- EOP handling: bus_eop in any non-IDLE state pulses pkt_end and returns to IDLE.
  - err_align = (bit counter != 0).
  - err_crc: token PIDs (pid[1:0]==01) require CRC5 residual 5'b01100. Data PIDs (pid[1:0]==11) require CRC16 residual 16'h800D. Handshake/special PIDs are not checked.
  - EOP in PID state (fewer than 8 bits) sets err_align and err_pid.
  - pkt_ok = no flag set.
- bus_sop in a non-IDLE state restarts in PID with state cleared. The aborted packet gets no pkt_end.
- bus_reset (level) forces IDLE and clears every output except pid. It takes priority over all other inputs.

## Timing
- byte_valid/byte_out: registered, asserted the cycle after the bit_valid completing the byte.
- pid_valid: the cycle after the 8th bit_valid.
- pkt_end plus status: the cycle after bus_eop.
- Simultaneous bit_valid and bus_eop: the bit is shifted and counted first; status reflects it.
- Simultaneous bus_sop and bus_eop: EOP completes the current packet, then the FSM enters PID.
- Throughput: one bit per cycle is supported (upstream delivers one bit per 4 cycles).

## Configuration
- RX_CRC_CHECK_EN defined: CRC5/CRC16 logic is present and err_crc is as specified.
- Undefined: CRC registers are removed, err_crc is tied 0, and pkt_ok ignores CRC. Bytes, including CRC bytes, are still emitted.

## Test plan
- SOP, ACK bits of 0xD2 LSB-first, EOP -> pid=4'h2, pid_valid once, no byte_valid, pkt_end with pkt_ok=1, byte_count=0.
- SETUP token bytes 0x2D,0x00,0x10 -> pid=4'hD; byte_out 0x00 then 0x10; pkt_ok=1, err_crc=0.
  - Same packet with last byte 0x11 -> err_crc=1, pkt_ok=0 (RX_CRC_CHECK_EN defined).
- DATA0 zero-length packet 0xC3,0x00,0x00 -> two byte_valid pulses, byte_count=2, pkt_ok=1.
- PID byte 0xD3 then 0x00 -> no pid_valid, err_pid=1, no byte_valid, pkt_end once.
- ACK 0xD2 followed by 5 extra bits then EOP -> err_align=1, pkt_ok=0.
  - Separately, 1027 bytes after the PID -> err_len=1, byte_count=1026.
- bus_reset asserted mid-DATA -> outputs 0 next cycle, no pkt_end.
  - A following SOP+ACK is decoded with pkt_ok=1.
